adder_result_stage: RTL and testbench

Downstream consumer of the pipelined 32-bit carry-lookahead adder. It registers operand pairs into the adder and tracks each in-flight operation through the adder's fixed latency. It captures each sum with a status-flag word and buffers results in a small FIFO with valid/ready backpressure. A credit count guarantees that no adder result is ever dropped.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/result_fifo.sv | 58 +++++
 rtl/adder_result_stage.sv | 160 ++++++++++++++++
 tb/tb_adder_result_stage.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder result stage.
//   FLAG_*        bit positions inside the 4-bit status word {V,C,N,Z}
//   adder_result_t packed {sum, flags} entry at the default width
//   ADDER_WIDTH / ADDER_LAT / RESULT_DEPTH default configuration
package adder_pkg;

  localparam int unsigned ADDER_WIDTH  = 32;
  localparam int unsigned ADDER_LAT    = 2;
  localparam int unsigned RESULT_DEPTH = 4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_W = 4;

  typedef struct packed {
    logic [ADDER_WIDTH-1:0] sum;
    logic [FLAG_W-1:0]      flags;
  } adder_result_t;

endpackage

// File: rtl/result_fifo.sv
// Circular-buffer FIFO holding adder results.
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write request and data (ignored when full unless popping)
//   pop           read request (ignored when empty)
//   rdata         head entry; zero while empty
//   count         number of stored entries, 0..DEPTH
//   full, empty   occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo #(
  parameter int unsigned DW    = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so push at full is fine then.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Gate the head so the visible outputs are zero whenever nothing is stored.
  assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/adder_result_stage.sv
// Issue/collect stage around a pipelined carry-lookahead adder.
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_cin   operand handshake (ready = credit left)
//   add_a/add_b/add_cin           registered operands driven to the adder
//   add_sum/add_cout              adder result, valid LAT cycles after operands
//   out_valid/out_ready/out_sum/out_flags  result FIFO head, flags {V,C,N,Z}
// Build option: define ADDRES_SAT_EN to saturate out_sum on signed overflow
// (flags still describe the raw wrapped sum).
module adder_result_stage
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH,
  parameter int unsigned LAT   = ADDER_LAT,
  parameter int unsigned DEPTH = RESULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_cin,
  output logic [WIDTH-1:0]  add_a,
  output logic [WIDTH-1:0]  add_b,
  output logic              add_cin,
  input  logic [WIDTH-1:0]  add_sum,
  input  logic              add_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic [FLAG_W-1:0] out_flags
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = WIDTH + FLAG_W;

  logic              accept;
  logic              pop;
  logic [CW-1:0]     crd_q;
  logic [CW-1:0]     crd_d;
  logic              op_q;
  logic [LAT-1:0]    vld_sr_q;
  logic [LAT-1:0]    sa_sr_q;
  logic [LAT-1:0]    sb_sr_q;
  logic [LAT:0]      vld_chain;
  logic [LAT:0]      sa_chain;
  logic [LAT:0]      sb_chain;
  logic              res_vld;
  logic              res_sa;
  logic              res_sb;
  logic [WIDTH-1:0]  res_sum;
  logic [FLAG_W-1:0] res_flags;
  logic [RW-1:0]     fifo_wdata;
  logic [RW-1:0]     fifo_rdata;
  logic [AW:0]       fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign in_ready = (crd_q != '0);

  // Operand registers; op_q marks that they hold an op issued at the last edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      op_q    <= 1'b0;
    end else begin
      op_q <= accept;
      if (accept) begin
        add_a   <= in_a;
        add_b   <= in_b;
        add_cin <= in_cin;
      end
    end
  end

  // Each op walks LAT stages alongside the adder pipeline, carrying its
  // operand signs for the overflow test; the chain's top bit is the exit.
  assign vld_chain = {vld_sr_q, op_q};
  assign sa_chain  = {sa_sr_q, add_a[WIDTH-1]};
  assign sb_chain  = {sb_sr_q, add_b[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q <= '0;
      sa_sr_q  <= '0;
      sb_sr_q  <= '0;
    end else begin
      vld_sr_q <= vld_chain[LAT-1:0];
      sa_sr_q  <= sa_chain[LAT-1:0];
      sb_sr_q  <= sb_chain[LAT-1:0];
    end
  end

  assign res_vld = vld_chain[LAT];
  assign res_sa  = sa_chain[LAT];
  assign res_sb  = sb_chain[LAT];

  always_comb begin
    res_flags         = '0;
    res_flags[FLAG_Z] = (add_sum == '0);
    res_flags[FLAG_N] = add_sum[WIDTH-1];
    res_flags[FLAG_C] = add_cout;
    res_flags[FLAG_V] = (res_sa == res_sb) & (add_sum[WIDTH-1] != res_sa);
    res_sum           = add_sum;
`ifdef ADDRES_SAT_EN
    if (res_flags[FLAG_V]) begin
      res_sum = res_sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign fifo_wdata = {res_sum, res_flags};

  // Credits count free FIFO slots minus ops still in flight.
  always_comb begin
    crd_d = crd_q;
    if (accept && !pop) begin
      crd_d = crd_q - 1'b1;
    end else if (pop && !accept) begin
      crd_d = crd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crd_q <= CW'(DEPTH);
    end else begin
      crd_q <= crd_d;
    end
  end

  result_fifo #(
    .DW    (RW),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_vld),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid            = ~fifo_empty;
  assign {out_sum, out_flags} = fifo_rdata;

  // The unconditional result write relies on these credit invariants.
  assert property (@(posedge clk) disable iff (rst) !(res_vld && fifo_full && !pop));
  assert property (@(posedge clk) disable iff (rst)
                   (32'(crd_q) + 32'(fifo_count)) <= DEPTH);

endmodule

// File: tb/tb_adder_result_stage.sv
module tb_adder_result_stage;
  import adder_pkg::*;

  localparam int unsigned WIDTH = ADDER_WIDTH;
  localparam int unsigned LAT   = ADDER_LAT;
  localparam int unsigned DEPTH = RESULT_DEPTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_flags;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adder_result_stage #(
    .WIDTH (WIDTH),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags)
  );

  // Pipelined adder stand-in: LAT register stages, not reset.
  logic [WIDTH:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign add_sum  = pipe[LAT-1][WIDTH-1:0];
  assign add_cout = pipe[LAT-1][WIDTH];

  // Reference result computed with integer arithmetic.
  function automatic adder_result_t model_add(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                              logic cin);
    adder_result_t r;
    longint us, ss, lim;
    logic v;
    us  = longint'(a) + longint'(b) + longint'(cin);
    ss  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    lim = longint'(1) << (WIDTH - 1);
    v   = (ss >= lim) || (ss < -lim);
    r.sum           = us[WIDTH-1:0];
    r.flags         = '0;
    r.flags[FLAG_Z] = (r.sum == '0);
    r.flags[FLAG_N] = r.sum[WIDTH-1];
    r.flags[FLAG_C] = us[WIDTH];
    r.flags[FLAG_V] = v;
`ifdef ADDRES_SAT_EN
    if (v) r.sum = (ss > 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    return r;
  endfunction

  // Transaction-level model: ops in accept order with the edge at which each
  // becomes visible; credit is simply DEPTH minus ops accepted and not popped.
  typedef struct {
    adder_result_t res;
    longint        vis;
  } mentry_t;

  mentry_t          mq[$];
  longint           cyc = 0;
  logic             exp_valid = 1'b0;
  logic             exp_ready = 1'b1;
  logic [WIDTH-1:0] exp_sum = '0;
  logic [3:0]       exp_flags = '0;
  logic [WIDTH-1:0] m_add_a = '0;
  logic [WIDTH-1:0] m_add_b = '0;
  logic             m_add_cin = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      exp_valid <= 1'b0;
      exp_ready <= 1'b1;
      exp_sum   <= '0;
      exp_flags <= '0;
      m_add_a   <= '0;
      m_add_b   <= '0;
      m_add_cin <= 1'b0;
    end else begin
      if (exp_valid && out_ready) void'(mq.pop_front());
      if (in_valid && exp_ready) begin
        mq.push_back('{res: model_add(in_a, in_b, in_cin), vis: cyc + LAT + 1});
        m_add_a   <= in_a;
        m_add_b   <= in_b;
        m_add_cin <= in_cin;
      end
      if (mq.size() > 0 && mq[0].vis <= cyc) begin
        exp_valid <= 1'b1;
        exp_sum   <= mq[0].res.sum;
        exp_flags <= mq[0].res.flags;
      end else begin
        exp_valid <= 1'b0;
      end
      exp_ready <= (mq.size() < int'(DEPTH));
    end
    cyc <= cyc + 1;
  end

  // Observation only: handshakes as they happen at each edge.
  logic [WIDTH-1:0] popped[$];
  int               n_acc = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) popped.push_back(out_sum);
      if (in_valid && in_ready) n_acc <= n_acc + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $fatal(1);
  end

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (LAT + DEPTH + 6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_sum !== '0) begin n_errors++;
      $display("FAIL reset_out_sum: got %h want 0", out_sum); end
    n_checks++; if (out_flags !== 4'b0) begin n_errors++;
      $display("FAIL reset_out_flags: got %b want 0000", out_flags); end
    n_checks++; if ({add_a, add_b, add_cin} !== '0) begin n_errors++;
      $display("FAIL reset_add_regs: got %h/%h/%b want 0", add_a, add_b, add_cin); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    drain();
    in_valid = 1'b1; in_a = 32'hFFFF_FFDC; in_b = 32'd36; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (add_a !== 32'hFFFF_FFDC || add_b !== 32'd36) begin n_errors++;
      $display("FAIL single_add_regs: got %h/%h want ffffffdc/24", add_a, add_b); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_errors++;
        $display("FAIL single_early_valid: edge +%0d got %b want 0", k, out_valid); end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b1) begin n_errors++;
      $display("FAIL single_valid: got %b want 1", out_valid); end
    n_checks++; if (out_sum !== 32'd0) begin n_errors++;
      $display("FAIL single_sum: got %h want 0", out_sum); end
    n_checks++; if (out_flags !== 4'b0101) begin n_errors++;
      $display("FAIL single_flags: got %b want 0101", out_flags); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++;
      $display("FAIL single_dup: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    drain();
    in_valid = 1'b1; in_a = 32'd352; in_b = 32'd18; in_cin = 1'b0;
    @(negedge clk);
    in_a = 32'd4; in_b = 32'd67;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd370 || out_flags !== 4'b0) begin
      n_errors++;
      $display("FAIL b2b_first: got v=%b sum=%0d fl=%b want v=1 sum=370 fl=0000",
               out_valid, out_sum, out_flags); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd71 || out_flags !== 4'b0) begin
      n_errors++;
      $display("FAIL b2b_second: got v=%b sum=%0d fl=%b want v=1 sum=71 fl=0000",
               out_valid, out_sum, out_flags); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++;
      $display("FAIL b2b_tail: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] want;
`ifdef ADDRES_SAT_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h8000_0000;
`endif
    drain();
    in_valid = 1'b1; in_a = 32'h7FFF_FFFF; in_b = 32'd1; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== want) begin n_errors++;
      $display("FAIL ovf_sum: got v=%b sum=%h want v=1 sum=%h", out_valid, out_sum, want); end
    n_checks++; if (out_flags !== 4'b1010) begin n_errors++;
      $display("FAIL ovf_flags: got %b want 1010", out_flags); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] opa [6];
    int acc0, pop0;
    drain();
    for (int i = 0; i < 6; i++) opa[i] = WIDTH'($urandom_range(0, 100000));
    acc0 = n_acc; pop0 = popped.size();
    out_ready = 1'b0; in_b = 32'd7; in_cin = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (n_acc - acc0 < 6);
      if (n_acc - acc0 < 6) in_a = opa[n_acc - acc0];
      @(negedge clk);
    end
    n_checks++; if (n_acc - acc0 != int'(DEPTH)) begin n_errors++;
      $display("FAIL bp_accepted: got %0d want %0d", n_acc - acc0, DEPTH); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++;
      $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_sum !== opa[0] + 7) begin n_errors++;
      $display("FAIL bp_head: got v=%b sum=%0d want v=1 sum=%0d", out_valid, out_sum,
               opa[0] + 7); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_errors++;
      $display("FAIL bp_ready_rise: got %b want 1", in_ready); end
    for (int c = 0; c < 20; c++) begin
      in_valid = (n_acc - acc0 < 6);
      if (n_acc - acc0 < 6) in_a = opa[n_acc - acc0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (n_acc - acc0 != 6 || popped.size() - pop0 != 6) begin n_errors++;
      $display("FAIL bp_totals: got acc=%0d pop=%0d want 6/6", n_acc - acc0,
               popped.size() - pop0); end
    for (int i = 0; i < 6 && pop0 + i < popped.size(); i++) begin
      n_checks++; if (popped[pop0 + i] !== opa[i] + 7) begin n_errors++;
        $display("FAIL bp_order[%0d]: got %0d want %0d", i, popped[pop0 + i], opa[i] + 7); end
    end
  endtask

  task automatic test_boundary();
    logic [WIDTH-1:0] opa [6];
    int acc0, pop0;
    drain();
    for (int i = 0; i < 6; i++) opa[i] = WIDTH'(1000 * (i + 1) + $urandom_range(0, 999));
    acc0 = n_acc; pop0 = popped.size();
    out_ready = 1'b0; in_b = 32'd0; in_cin = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_a = opa[n_acc - acc0];
      @(negedge clk);
    end
    n_checks++; if (n_acc - acc0 != 4 || in_ready !== 1'b0) begin n_errors++;
      $display("FAIL bnd_full: got acc=%0d rdy=%b want 4/0", n_acc - acc0, in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || n_acc - acc0 != 4) begin n_errors++;
      $display("FAIL bnd_pop_only: got rdy=%b acc=%0d want 1/4", in_ready, n_acc - acc0); end
    @(negedge clk);
    n_checks++; if (n_acc - acc0 != 5 || in_ready !== 1'b1) begin n_errors++;
      $display("FAIL bnd_simul: got acc=%0d rdy=%b want 5/1", n_acc - acc0, in_ready); end
    out_ready = 1'b0;
    in_a = opa[5];
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (n_acc - acc0 != 6 || in_ready !== 1'b0) begin n_errors++;
      $display("FAIL bnd_credit: got acc=%0d rdy=%b want 6/0", n_acc - acc0, in_ready); end
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++; if (popped.size() - pop0 != 6) begin n_errors++;
      $display("FAIL bnd_count: got %0d want 6", popped.size() - pop0); end
    for (int i = 0; i < 6 && pop0 + i < popped.size(); i++) begin
      n_checks++; if (popped[pop0 + i] !== opa[i] + 1) begin n_errors++;
        $display("FAIL bnd_order[%0d]: got %0d want %0d", i, popped[pop0 + i], opa[i] + 1); end
    end
  endtask

  task automatic test_reset_midflight();
    int acc0, pop0;
    drain();
    out_ready = 1'b0; in_b = 32'd5; in_cin = 1'b0;
    in_valid = 1'b1; in_a = 32'd10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1; in_a = 32'd20;
    @(negedge clk);
    in_a = 32'd30;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd15) begin n_errors++;
      $display("FAIL rstmid_pre: got v=%b sum=%0d want v=1 sum=15", out_valid, out_sum); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
      n_errors++;
      $display("FAIL rstmid_after: got v=%b rdy=%b sum=%0d want 0/1/0", out_valid, in_ready,
               out_sum); end
    pop0 = popped.size();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_errors++;
        $display("FAIL rstmid_late[%0d]: got out_valid %b want 0", k, out_valid); end
    end
    acc0 = n_acc;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_a = WIDTH'(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (n_acc - acc0 != int'(DEPTH) || popped.size() != pop0) begin n_errors++;
      $display("FAIL rstmid_credits: got acc=%0d pops=%0d want %0d/0", n_acc - acc0,
               popped.size() - pop0, DEPTH); end
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return {1'b0, {(WIDTH-1){1'b1}}};
      1:       return {1'b1, {(WIDTH-1){1'b0}}};
      2:       return '0;
      3:       return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic test_random();
    drain();
    for (int c = 0; c < 400; c++) begin
      n_checks++; if (out_valid !== exp_valid) begin n_errors++;
        $display("FAIL rnd_out_valid @%0d: got %b want %b", c, out_valid, exp_valid); end
      n_checks++; if (in_ready !== exp_ready) begin n_errors++;
        $display("FAIL rnd_in_ready @%0d: got %b want %b", c, in_ready, exp_ready); end
      n_checks++; if (add_a !== m_add_a || add_b !== m_add_b || add_cin !== m_add_cin) begin
        n_errors++;
        $display("FAIL rnd_add_regs @%0d: got %h/%h/%b want %h/%h/%b", c, add_a, add_b,
                 add_cin, m_add_a, m_add_b, m_add_cin); end
      if (exp_valid) begin
        n_checks++; if (out_sum !== exp_sum || out_flags !== exp_flags) begin n_errors++;
          $display("FAIL rnd_head @%0d: got %h/%b want %h/%b", c, out_sum, out_flags,
                   exp_sum, exp_flags); end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ((c % 64) < 32) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_a      = rand_operand();
      in_b      = ($urandom_range(0, 7) == 0) ? -in_a : rand_operand();
      in_cin    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_boundary();
    test_reset_midflight();
    test_random();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
